// File: rtl/pour3_unit.sv
// Shot dispenser controller: counts down loaded shots, opening the valve for a
// fixed pour time per request, then settling before a four-phase acknowledgement.
module pour3_unit #(
    parameter int POUR_TICKS = 16,
    parameter int GAP_TICKS  = 4,
    parameter int TMR_W      = 8
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       cnt3_ld,
    input  logic       cnt3_clr,
    input  logic       count2,
    input  logic [2:0] shots_in,
    output logic       count_ACK2,
    output logic       eq_0,
    output logic [2:0] shots_left,
    output logic       valve_on,
    output logic       busy
);

    if (POUR_TICKS < 1 || longint'(POUR_TICKS) > (longint'(1) << TMR_W)) begin : g_bad_pour
        $error("pour3_unit: POUR_TICKS out of range for TMR_W");
    end
    if (GAP_TICKS < 1 || longint'(GAP_TICKS) > (longint'(1) << TMR_W)) begin : g_bad_gap
        $error("pour3_unit: GAP_TICKS out of range for TMR_W");
    end

    typedef enum logic [1:0] {IDLE, POUR, GAP, ACK} state_t;

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [2:0]       shots_q;
    logic             ld_q;
    logic             ld_edge;

    assign ld_edge = cnt3_ld & ~ld_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            shots_q <= '0;
            ld_q    <= 1'b0;
        end else begin
            ld_q <= cnt3_ld;
            if (cnt3_clr) begin
                state_q <= IDLE;
                tmr_q   <= '0;
                shots_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ld_edge) shots_q <= shots_in;
                        // Empty counter acknowledges at once without pouring
                        if (count2) begin
                            if (shots_q != 3'd0) begin
                                state_q <= POUR;
                                tmr_q   <= TMR_W'(POUR_TICKS - 1);
                            end else begin
                                state_q <= ACK;
                            end
                        end
                    end
                    POUR: begin
                        if (tmr_q == '0) begin
                            state_q <= GAP;
                            tmr_q   <= TMR_W'(GAP_TICKS - 1);
                            if (shots_q != 3'd0) shots_q <= shots_q - 3'd1;
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end
                    GAP: begin
                        if (tmr_q == '0) state_q <= ACK;
                        else             tmr_q   <= tmr_q - TMR_W'(1);
                    end
                    ACK: begin
                        if (!count2) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign valve_on   = (state_q == POUR);
    assign count_ACK2 = (state_q == ACK);
    assign busy       = (state_q != IDLE);
    assign shots_left = shots_q;
    assign eq_0       = (shots_q == 3'd0);

endmodule
